alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
Upstream operand-entry stage for the 4-bit ALU board demo.
- Debounces a single "next" push-button.
- Steps through capturing operand A, operand B and the function code from the board switches.
- Presents the registered a/b/func to the ALU and flags when a complete operation is loaded.
- Sits between the board switches/buttons and the ALU's a, b, func inputs.

Parameters:
- DATA_W, 4, operand width; equals the ALU operand width.
- FUNC_W, 3, function-code width; equals the ALU func width.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced button level changes; legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_data  in  DATA_W  data switches, raw and asynchronous
- sw_func  in  FUNC_W  function switches, raw and asynchronous
- btn_next  in  1  raw push-button, active-high, bouncy
- btn_clr  in  1  raw clear button, active-high
- a  out  DATA_W  registered operand A to the ALU
- b  out  DATA_W  registered operand B to the ALU
- func  out  FUNC_W  registered function code to the ALU
- op_valid  out  1  high while in S_RUN (operands complete)
- op_start  out  1  one-cycle pulse on entry to S_RUN
- stage  out  2  current state encoding, for LEDs

Behaviour:
- Clock and reset: single clock domain; rst_n is asynchronous and active-low.
- Reset values: a=0, b=0, func=0, op_valid=0, op_start=0, stage=S_A, synchronisers=0, debounced level=0, debounce counter=0.
- Input synchronisation: btn_next and btn_clr each pass through a 2-flop synchroniser. sw_data and sw_func are sampled directly at commit; they are quasi-static.
- Debounce of btn_next:
  - The counter increments while the synchronised level differs from the debounced level, and clears to 0 when they match.
  - The debounced level toggles on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that same edge.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: an internal "press" is the 0->1 transition of the debounced level. A release produces no event. Holding the button produces exactly one press.
- Press latency: the press commits on the edge 2+DEBOUNCE_CYCLES edges after btn_next is first sampled high and held stable.
- States (stage encoding): S_A=0, S_B=1, S_F=2, S_RUN=3.
  - S_A + press: a<=sw_data, go to S_B.
  - S_B + press: b<=sw_data, go to S_F.
  - S_F + press: func<=sw_func, go to S_RUN, op_start=1 for the following cycle only.
  - S_RUN + press: go to S_A; a/b/func are retained until overwritten.
  - No press: hold state and registers.
- op_valid is registered and equals (stage==S_RUN); it rises in the same cycle as op_start.
- Clear:
  - The synchronised btn_clr high forces stage=S_A and a=b=func=0, op_valid=0, op_start=0 on every cycle it is high.
  - Clear takes priority over a simultaneous press; that press is discarded and not deferred.
  - Clear does not reset the debounce state, so a button held through clear produces no new press until it is released and pressed again.
- Reset mid-debounce: the counter and debounced level return to 0; a button still held after reset release is detected as a fresh press after 2+DEBOUNCE_CYCLES cycles.
- Counter width: $clog2(DEBOUNCE_CYCLES+1) bits; no wrap, since it saturates by toggling.
- Outputs are driven straight from flops with no combinational path from inputs, so the ALU sees glitch-free operands.

Decomposition:
- Package alu_seq_pkg:
  - state enum seq_state_t {S_A, S_B, S_F, S_RUN} as 2-bit values 0..3;
  - localparams DATA_W=4 and FUNC_W=3, matching the ALU.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
  - contains the 2-flop synchroniser, counter and debounced level;
  - outputs level and rise_pulse;
  - instantiated once for btn_next.
- btn_clr uses only a 2-flop synchroniser, inline.

Test Plan:
- Entry sequence (DEBOUNCE_CYCLES=4): reset, then three clean presses with sw_data=4'h5, then 4'hA, then sw_func=3'b001 -> a=5, b=A, func=1, stage=3, op_valid=1. op_start high for exactly one cycle. Each commit occurs 6 edges after btn_next is first sampled high.
- Bounce rejection: btn_next toggled high for 3 cycles, low for 1, high for 3, then low -> no press, stage stays S_A, a=0. A final stable high of 4+ cycles produces exactly one press.
- Hold: btn_next held high for 100 cycles in S_A -> exactly one transition to S_B; no further advance until release plus a new press.
- Wrap: a fourth press in S_RUN -> stage=S_A, op_valid=0, a/b/func unchanged (5, A, 1).
- Clear priority: btn_clr synchronised high on the same edge as a press in S_F -> stage=S_A, a=b=func=0, no op_start.
- Async reset mid-debounce: rst_n low for 1 cycle while the counter=2 -> all outputs 0 immediately (before the next clk edge). A held button yields a press 6 cycles after reset release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operand-entry stage.
// Contents: operand/function widths matching the ALU, and the entry-sequence
// state type whose encoding is shown directly on the stage LEDs.
package alu_seq_pkg;

    localparam int DATA_W = 4;
    localparam int FUNC_W = 3;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_F   = 2'd2,
        S_RUN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and debounced level.
// Ports: clk, rst_n, btn_raw in; level (debounced) and rise_pulse (one cycle after a 0->1) out.
// Latency: level changes DEBOUNCE_CYCLES+1 edges after the raw input is first sampled stable.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; it toggles the level instead of reaching DEBOUNCE_CYCLES,
    // so it can never wrap.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand-entry sequencer: each debounced "next" press captures A, then B, then func, then re-arms.
// Ports: clk, rst_n, raw switches/buttons in; registered a, b, func, op_valid, op_start, stage out.
// Latency: a press commits 2+DEBOUNCE_CYCLES edges after btn_next is first sampled high; clear wins.
module alu_operand_sequencer #(
    parameter int DATA_W          = alu_seq_pkg::DATA_W,
    parameter int FUNC_W          = alu_seq_pkg::FUNC_W,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [FUNC_W-1:0] sw_func,
    input  logic              btn_next,
    input  logic              btn_clr,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [FUNC_W-1:0] func,
    output logic              op_valid,
    output logic              op_start,
    output logic [1:0]        stage
);

    import alu_seq_pkg::*;

    logic              press;
    logic              next_level_unused;
    logic              clr_s1_q;
    logic              clr_s2_q;
    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_d;
    logic [FUNC_W-1:0] func_q;
    logic [FUNC_W-1:0] func_d;
    logic              op_valid_q;
    logic              op_valid_d;
    logic              op_start_q;
    logic              op_start_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_next),
        .level      (next_level_unused),
        .rise_pulse (press)
    );

    // Clear only needs metastability protection; it acts level-wise every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
        end else begin
            clr_s1_q <= btn_clr;
            clr_s2_q <= clr_s1_q;
        end
    end

    // A press coinciding with clear is dropped, not queued.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        func_d     = func_q;
        op_start_d = 1'b0;
        if (clr_s2_q) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            func_d  = '0;
        end else if (press) begin
            unique case (state_q)
                S_A: begin
                    a_d     = sw_data;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_data;
                    state_d = S_F;
                end
                S_F: begin
                    func_d     = sw_func;
                    state_d    = S_RUN;
                    op_start_d = 1'b1;
                end
                S_RUN: begin
                    state_d = S_A;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
        // Registered from the next state so it rises together with op_start.
        op_valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            func_q     <= '0;
            op_valid_q <= 1'b0;
            op_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            func_q     <= func_d;
            op_valid_q <= op_valid_d;
            op_start_q <= op_start_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign func     = func_q;
    assign op_valid = op_valid_q;
    assign op_start = op_start_q;
    assign stage    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with DEBOUNCE_CYCLES=4: directed entry/bounce/hold/wrap/clear/reset
// sequences followed by random button traffic. A reference model predicts every change of the output
// tuple (with its cycle); a monitor compares each observed change against the predicted queue.
module tb_alu_operand_sequencer;

    localparam int DC = 4;

    typedef struct packed {
        logic [1:0] stage;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] func;
        logic       vld;
        logic       start;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] sw_data = '0;
    logic [2:0] sw_func = '0;
    logic       btn_next = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] func;
    logic       op_valid;
    logic       op_start;
    logic [1:0] stage;

    alu_operand_sequencer #(
        .DATA_W(4),
        .FUNC_W(3),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_data  (sw_data),
        .sw_func  (sw_func),
        .btn_next (btn_next),
        .btn_clr  (btn_clr),
        .a        (a),
        .b        (b),
        .func     (func),
        .op_valid (op_valid),
        .op_start (op_start),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    obs_t dut_o;
    assign dut_o = {stage, a, b, func, op_valid, op_start};

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;
    ev_t exp_q[$];

    // ---------------- reference model ----------------
    // Button behaviour from the rules: inputs are seen two edges late; the
    // debounced level flips once the last DC seen values all disagree with it;
    // a rising level is acted on at the following edge.
    bit   raw_hist[$];
    bit   clr_hist[$];
    bit   seen_hist[$];
    bit   lvl  = 1'b0;
    bit   pend = 1'b0;
    obs_t m      = '0;
    obs_t m_last = '0;

    always @(posedge clk or negedge rst_n) begin
        int  stamp;
        bit  s_btn;
        bit  s_clr;
        bit  do_press;
        bit  all_diff;
        if (clk) cyc++;
        if (!rst_n) begin
            raw_hist.delete();
            clr_hist.delete();
            seen_hist.delete();
            lvl  = 1'b0;
            pend = 1'b0;
            m    = '0;
            // A reset asserted in the low phase is first observed after the next edge.
            stamp = clk ? cyc : cyc + 1;
        end else begin
            stamp = cyc;
            s_btn = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
            s_clr = (clr_hist.size() >= 2) ? clr_hist[clr_hist.size()-2] : 1'b0;
            raw_hist.push_back(btn_next);
            clr_hist.push_back(btn_clr);
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            if (clr_hist.size() > 2) void'(clr_hist.pop_front());

            do_press = pend;
            pend     = 1'b0;
            m.start  = 1'b0;
            if (s_clr) begin
                m = '0;
            end else if (do_press) begin
                case (m.stage)
                    2'd0:    begin m.a = sw_data; m.stage = 2'd1; end
                    2'd1:    begin m.b = sw_data; m.stage = 2'd2; end
                    2'd2:    begin m.func = sw_func; m.stage = 2'd3; m.start = 1'b1; end
                    default: m.stage = 2'd0;
                endcase
            end
            m.vld = (m.stage == 2'd3);

            seen_hist.push_back(s_btn);
            if (seen_hist.size() > DC) void'(seen_hist.pop_front());
            if (seen_hist.size() == DC) begin
                all_diff = 1'b1;
                foreach (seen_hist[i]) if (seen_hist[i] == lvl) all_diff = 1'b0;
                if (all_diff) begin
                    lvl  = ~lvl;
                    pend = lvl;
                end
            end
        end
        if (m != m_last) begin
            exp_q.push_back('{cyc: stamp, o: m});
            m_last = m;
        end
    end

    // ---------------- monitor ----------------
    obs_t prev = '0;

    always @(negedge clk) begin
        ev_t e;
        if (mon_en && (dut_o !== prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, dut_o);
            end else begin
                e = exp_q.pop_front();
                if (e.o !== dut_o || e.cyc != cyc) begin
                    failures++;
                    $display("FAIL output_change got=%h@cyc%0d expected=%h@cyc%0d",
                             dut_o, cyc, e.o, e.cyc);
                end
            end
            prev = dut_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int hold);
        btn_next = 1'b1;
        tick(hold);
        btn_next = 1'b0;
        tick(DC + 6);
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check_eq("reset_outputs", 32'(dut_o), 32'h0);
        mon_en = 1'b1;
        @(posedge clk);
        #2;

        // Bounce: 3 high, 1 low, 3 high never stays stable for DC seen cycles.
        btn_next = 1'b1; tick(3);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(3);
        btn_next = 1'b0; tick(10);
        check_eq("bounce_stage", 32'(stage), 32'd0);
        check_eq("bounce_a", 32'(a), 32'h0);

        // Entry sequence.
        sw_data = 4'h5; press(6);
        check_eq("entry_a_stage", 32'(stage), 32'd1);
        sw_data = 4'hA; press(6);
        sw_func = 3'b001; press(6);
        check_eq("entry_tuple", 32'({stage, a, b, func, op_valid}), 32'({2'd3, 4'h5, 4'hA, 3'd1, 1'b1}));

        // Wrap back to S_A, operands retained.
        sw_data = 4'hF; sw_func = 3'd6; press(6);
        check_eq("wrap_tuple", 32'({stage, a, b, func, op_valid}), 32'({2'd0, 4'h5, 4'hA, 3'd1, 1'b0}));

        // Hold for 100 cycles: a single advance.
        sw_data = 4'h7;
        btn_next = 1'b1; tick(100);
        check_eq("hold_stage", 32'(stage), 32'd1);
        check_eq("hold_a", 32'(a), 32'h7);
        btn_next = 1'b0; tick(10);
        check_eq("hold_release_stage", 32'(stage), 32'd1);
        sw_data = 4'h3; press(6);
        check_eq("to_sf_stage", 32'(stage), 32'd2);

        // Clear lands on the same edge as the S_F press (clr sampled 4 edges after btn).
        sw_func = 3'd5;
        btn_next = 1'b1; tick(4);
        btn_clr = 1'b1; tick(1);
        btn_clr = 1'b0; tick(6);
        btn_next = 1'b0; tick(10);
        check_eq("clear_tuple", 32'({stage, a, b, func, op_valid}), 32'h0);

        // Load something, then reset in the middle of the next debounce.
        sw_data = 4'h9; press(6);
        check_eq("pre_reset_a", 32'(a), 32'h9);
        btn_next = 1'b1; tick(4);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_eq("async_reset_outputs", 32'(dut_o), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        sw_data = 4'hC;
        tick(12);
        btn_next = 1'b0; tick(10);
        check_eq("post_reset_press", 32'({stage, a}), 32'({2'd1, 4'hC}));

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            sw_data  = 4'($urandom);
            sw_func  = 3'($urandom);
            btn_next = 1'($urandom_range(0, 1));
            btn_clr  = ($urandom_range(0, 15) == 0);
            tick($urandom_range(1, 8));
        end
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        tick(20);
        check_eq("pending_expectations", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
